// File: rtl/alu_sys_pkg.sv
// Shared types and helpers for the ALU result path into the UART TX FIFO.
package alu_sys_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int num_bytes(input int width);
    return (2 * width) / BYTE_W;
  endfunction

endpackage

// File: rtl/alu_result_sender.sv
// Captures an ALU result on a rising edge of OUT_VALID and streams it
// LSB-byte-first into the TX FIFO, honouring FIFO_FULL back-pressure.
module alu_result_sender #(
  parameter int WIDTH  = 16,
  parameter int BYTE_W = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               OUT_VALID,
  input  logic               FIFO_FULL,
  output logic [BYTE_W-1:0]  WR_DATA,
  output logic               WR_INC,
  output logic               BUSY,
  output logic               DROP_FLAG
);
  import alu_sys_pkg::*;

  localparam int NUM_BYTES = num_bytes(WIDTH);
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  generate
    if ((2 * WIDTH) % 8 != 0) begin : g_width_check
      $error("alu_result_sender: 2*WIDTH must be a multiple of 8");
    end
  endgenerate

  state_t             state_reg;
  logic [2*WIDTH-1:0] hold_reg;
  logic [IDX_W-1:0]   byte_idx;
  logic               valid_d;
  logic               drop_reg;

  logic [BYTE_W-1:0]  byte_lane [NUM_BYTES];
  logic               new_res;
  logic               sending;
  logic               wr_fire;
  logic               last_wr;

  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign byte_lane[gi] = hold_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Outputs are gated by RST so an in-flight transfer stops writing in the reset cycle itself.
  assign new_res = OUT_VALID & ~valid_d;
  assign sending = (state_reg == SEND) & ~RST;
  assign wr_fire = sending & ~FIFO_FULL;
  assign last_wr = wr_fire & (byte_idx == LAST_IDX);

  assign WR_INC    = wr_fire;
  assign WR_DATA   = sending ? byte_lane[byte_idx] : '0;
  assign BUSY      = sending;
  assign DROP_FLAG = drop_reg;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      byte_idx  <= '0;
      valid_d   <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      valid_d  <= OUT_VALID;
      drop_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (new_res) begin
            hold_reg  <= ALU_OUT;
            byte_idx  <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (last_wr) begin
            // A result arriving with the final write chains straight into the next transfer.
            if (new_res) begin
              hold_reg <= ALU_OUT;
              byte_idx <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            if (wr_fire) begin
              byte_idx <= byte_idx + 1'b1;
            end
            if (new_res) begin
              drop_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_sender.sv
// Scoreboard bench for alu_result_sender: stimulus pushes expected bytes,
// a negedge monitor pops and compares every FIFO write.
module tb_alu_result_sender;

  logic        clk;
  logic        RST;
  logic [31:0] ALU_OUT;
  logic        OUT_VALID;
  logic        FIFO_FULL;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        BUSY;
  logic        DROP_FLAG;

  int total;
  int bad;
  int exp_drops;
  int obs_drops;
  logic [7:0] exp_q [$];

  alu_result_sender #(.WIDTH(16), .BYTE_W(8)) dut (
    .clk       (clk),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .FIFO_FULL (FIFO_FULL),
    .WR_DATA   (WR_DATA),
    .WR_INC    (WR_INC),
    .BUSY      (BUSY),
    .DROP_FLAG (DROP_FLAG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic drain(input string name);
    repeat (8) tick();
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_drops"}, obs_drops, exp_drops);
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (DROP_FLAG) obs_drops++;
    if (WR_INC) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(WR_DATA), 256);
      end else begin
        check("wr_byte", int'(WR_DATA), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int busy_cnt;
    logic busy_run;
    total = 0; bad = 0; exp_drops = 0; obs_drops = 0;
    RST = 1'b1; ALU_OUT = '0; OUT_VALID = 1'b0; FIFO_FULL = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_wr_inc", WR_INC, 0);
    check("rst_busy", BUSY, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_drop", DROP_FLAG, 0);
    RST = 1'b0;
    tick();
    check("post_rst_busy", BUSY, 0);

    // Single result, 1-cycle valid pulse
    ALU_OUT = 32'hA1B2C3D4; OUT_VALID = 1'b1; push_word(32'hA1B2C3D4);
    tick();
    OUT_VALID = 1'b0;
    busy_cnt = 0;
    repeat (8) begin
      if (BUSY) busy_cnt++;
      tick();
    end
    check("single_busy_cycles", busy_cnt, 4);
    check("single_idle_wr_data", WR_DATA, 0);
    drain("single");

    // Level-held valid: accepted exactly once
    ALU_OUT = 32'h00000011; OUT_VALID = 1'b1; push_word(32'h00000011);
    repeat (10) tick();
    OUT_VALID = 1'b0;
    drain("level");

    // Back-pressure in cycles 2-4 of the transfer
    ALU_OUT = 32'h12345678; OUT_VALID = 1'b1; push_word(32'h12345678);
    tick();
    OUT_VALID = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      FIFO_FULL = (c >= 2 && c <= 4);
      #1;
      if (c >= 2 && c <= 4) begin
        check("stall_wr_inc", WR_INC, 0);
        check("stall_wr_data", WR_DATA, 8'h56);
      end
      if (BUSY) busy_cnt++;
      tick();
    end
    FIFO_FULL = 1'b0;
    check("bp_busy_cycles", busy_cnt, 7);
    drain("backpressure");

    // Overrun: second edge while byte 1 is being written
    ALU_OUT = 32'hCAFEF00D; OUT_VALID = 1'b1; push_word(32'hCAFEF00D);
    tick();
    OUT_VALID = 1'b0;
    tick();
    ALU_OUT = 32'hDEADBEEF; OUT_VALID = 1'b1; exp_drops++;
    tick();
    OUT_VALID = 1'b0;
    drain("overrun");

    // Back-to-back: new edge coincident with the last-byte write
    ALU_OUT = 32'h01020304; OUT_VALID = 1'b1; push_word(32'h01020304);
    tick();
    OUT_VALID = 1'b0;
    busy_cnt = 0; busy_run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) begin
        ALU_OUT = 32'h05060708; OUT_VALID = 1'b1; push_word(32'h05060708);
      end else begin
        OUT_VALID = 1'b0;
      end
      if (BUSY) busy_cnt++;
      if (c <= 8 && !BUSY) busy_run = 1'b0;
      tick();
    end
    check("b2b_busy_cycles", busy_cnt, 8);
    check("b2b_no_gap", busy_run, 1);
    drain("b2b");

    // Reset after two bytes, then a fresh result starts at byte 0
    ALU_OUT = 32'h11223344; OUT_VALID = 1'b1;
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    tick();
    OUT_VALID = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    #1;
    check("midrst_wr_inc", WR_INC, 0);
    check("midrst_busy", BUSY, 0);
    tick();
    RST = 1'b0;
    #1;
    check("after_rst_wr_inc", WR_INC, 0);
    check("after_rst_busy", BUSY, 0);
    tick();
    ALU_OUT = 32'h55667788; OUT_VALID = 1'b1; push_word(32'h55667788);
    tick();
    OUT_VALID = 1'b0;
    drain("rst_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
